// File: rtl/sme_line_feeder.sv
// Line framer for the string-matching engine: buffers one LF-terminated line,
// replays it as a gap-free isstring/ispattern burst, then waits for the result.
module sme_line_feeder #(
    parameter int STR_MAX     = 32,
    parameter int PAT_MAX     = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       sme_valid,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    output logic       busy,
    output logic       err_overflow,
    output logic       err_nostr,
    output logic       err_timeout
);

    localparam int STR_AW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int PAT_AW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [5:0]    STR_MAX_L    = 6'(STR_MAX);
    localparam logic [5:0]    PAT_MAX_L    = 6'(PAT_MAX);
    localparam logic [5:0]    LEN_SAT      = 6'h3F;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    SOH          = 8'h01;
    localparam logic [7:0]    LF           = 8'h0A;

    typedef enum logic [1:0] {
        COLLECT,
        SEND_STR,
        SEND_PAT,
        WAIT_RES
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      len_q, len_d;
    logic [5:0]      send_len_q, send_len_d;
    logic [5:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            first_q, first_d;
    logic            str_line_q, str_line_d;
    logic            have_str_q, have_str_d;
    logic [7:0]      chardata_q, chardata_d;
    logic            isstring_q, isstring_d;
    logic            ispattern_q, ispattern_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_nostr_q, err_nostr_d;
    logic            err_to_q, err_to_d;
    logic            str_we, pat_we;
    logic            accept;

    logic [7:0] str_buf [STR_MAX];
    logic [7:0] pat_buf [PAT_MAX];

    assign in_ready = (state_q == COLLECT) & ~reset;
    assign accept   = in_valid & in_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        len_d       = len_q;
        send_len_d  = send_len_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        first_d     = first_q;
        str_line_d  = str_line_q;
        have_str_d  = have_str_q;
        chardata_d  = chardata_q;
        isstring_d  = isstring_q;
        ispattern_d = ispattern_q;
        err_ovf_d   = err_ovf_q;
        err_nostr_d = err_nostr_q;
        err_to_d    = err_to_q;
        str_we      = 1'b0;
        pat_we      = 1'b0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (in_data == LF) begin
                        first_d = 1'b1;
                        len_d   = '0;
                        // Zero-length lines (LF alone, SOH+LF) fall through untouched.
                        if (len_q != '0) begin
                            if (str_line_q) begin
                                state_d    = SEND_STR;
                                send_len_d = (len_q > STR_MAX_L) ? STR_MAX_L : len_q;
                                idx_d      = '0;
                                have_str_d = 1'b1;
                            end else if (have_str_q) begin
                                state_d    = SEND_PAT;
                                send_len_d = (len_q > PAT_MAX_L) ? PAT_MAX_L : len_q;
                                idx_d      = '0;
                            end else begin
                                err_nostr_d = 1'b1;
                            end
                        end
                    end else if (first_q) begin
                        first_d    = 1'b0;
                        str_line_d = (in_data == SOH);
                        if (in_data != SOH) begin
                            pat_we = 1'b1;
                            len_d  = 6'd1;
                        end
                    end else begin
                        if (str_line_q) begin
                            if (len_q < STR_MAX_L) str_we = 1'b1;
                            else                   err_ovf_d = 1'b1;
                        end else begin
                            if (len_q < PAT_MAX_L) pat_we = 1'b1;
                            else                   err_ovf_d = 1'b1;
                        end
                        if (len_q != LEN_SAT) len_d = len_q + 6'd1;
                    end
                end
            end
            SEND_STR, SEND_PAT: begin
                if (idx_q < send_len_q) begin
                    chardata_d  = (state_q == SEND_STR) ? str_buf[idx_q[STR_AW-1:0]]
                                                        : pat_buf[idx_q[PAT_AW-1:0]];
                    isstring_d  = (state_q == SEND_STR);
                    ispattern_d = (state_q == SEND_PAT);
                    idx_d       = idx_q + 6'd1;
                end else begin
                    chardata_d  = 8'h00;
                    isstring_d  = 1'b0;
                    ispattern_d = 1'b0;
                    timer_d     = '0;
                    state_d     = (state_q == SEND_STR) ? COLLECT : WAIT_RES;
                end
            end
            WAIT_RES: begin
                // A result arriving on the last timer cycle still counts as success.
                if (sme_valid) begin
                    state_d = COLLECT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = COLLECT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            len_q       <= '0;
            send_len_q  <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            first_q     <= 1'b1;
            str_line_q  <= 1'b0;
            have_str_q  <= 1'b0;
            chardata_q  <= 8'h00;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_nostr_q <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            send_len_q  <= send_len_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            first_q     <= first_d;
            str_line_q  <= str_line_d;
            have_str_q  <= have_str_d;
            chardata_q  <= chardata_d;
            isstring_q  <= isstring_d;
            ispattern_q <= ispattern_d;
            err_ovf_q   <= err_ovf_d;
            err_nostr_q <= err_nostr_d;
            err_to_q    <= err_to_d;
        end
    end

    // NOTE: line buffers carry no reset; only positions below the captured length are ever read.
    always_ff @(posedge clk) begin
        if (str_we) str_buf[len_q[STR_AW-1:0]] <= in_data;
        if (pat_we) pat_buf[len_q[PAT_AW-1:0]] <= in_data;
    end

    assign chardata     = chardata_q;
    assign isstring     = isstring_q;
    assign ispattern    = ispattern_q;
    assign busy         = (state_q != COLLECT);
    assign err_overflow = err_ovf_q;
    assign err_nostr    = err_nostr_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_sme_line_feeder.sv
// Self-checking bench for sme_line_feeder: table of lines with expected burst
// lengths and sticky flags, a character scoreboard, and a mid-burst reset case.
module tb_sme_line_feeder;

    localparam int TIMEOUT_CYC = 64;
    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] LF  = 8'h0A;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       sme_valid;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       busy;
    logic       err_overflow;
    logic       err_nostr;
    logic       err_timeout;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        bit         is_pat;
        logic [7:0] ch;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        bit         rst;
        bit         is_str;
        int         n;
        logic [7:0] ch0;
        int         sme_cyc;   // WAIT_RES cycle (1-based) carrying sme_valid; 0 = never
        int         exp_out;
        bit         e_ovf;
        bit         e_nostr;
        bit         e_to;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    sme_line_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .sme_valid    (sme_valid),
        .chardata     (chardata),
        .isstring     (isstring),
        .ispattern    (ispattern),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_nostr    (err_nostr),
        .err_timeout  (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: every active cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (isstring || ispattern) begin
            check("exclusive_flags", {31'b0, isstring & ispattern}, 0);
            check("sb_has_entry", {31'b0, sb.size() > 0}, 1);
            if (sb.size() > 0) begin
                sb_t e;
                e = sb.pop_front();
                check("sb_type", {31'b0, ispattern}, {31'b0, e.is_pat});
                check("sb_char", {24'b0, chardata}, {24'b0, e.ch});
            end
        end else begin
            check("idle_chardata", {24'b0, chardata}, 0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit sent = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 200; t++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                sent = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!sent) check("send_byte_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        sme_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_low", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_high", {31'b0, in_ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_outputs", {22'b0, isstring, ispattern, chardata}, 0);
        check("rst_flags", {29'b0, err_overflow, err_nostr, err_timeout}, 0);
    endtask

    task automatic run_vec(input vec_t t);
        int cnt;
        int bad;
        sb_t e;
        if (t.rst) do_reset();
        for (int i = 0; i < t.exp_out; i++) begin
            e.is_pat = !t.is_str;
            e.ch     = 8'(t.ch0 + 8'(i));
            sb.push_back(e);
        end
        if (t.is_str) send_byte(SOH);
        for (int i = 0; i < t.n; i++) send_byte(8'(t.ch0 + 8'(i)));
        send_byte(LF);

        @(negedge clk);
        check("lat_busy", {31'b0, busy}, {31'b0, t.exp_out > 0});
        check("lat_idle", {31'b0, isstring | ispattern}, 0);

        if (t.exp_out > 0) begin
            @(negedge clk);
            cnt = 0;
            while ((isstring || ispattern) && cnt < 100) begin
                cnt++;
                @(negedge clk);
            end
            check("burst_len", cnt, t.exp_out);
            if (t.is_str) begin
                check("str_done_busy", {31'b0, busy}, 0);
                check("str_done_ready", {31'b0, in_ready}, 1);
            end else begin
                check("wait_busy", {31'b0, busy}, 1);
                bad = 0;
                for (int c = 1; c <= TIMEOUT_CYC; c++) begin
                    if (in_ready) bad++;
                    if (c == t.sme_cyc) begin
                        sme_valid = 1'b1;
                        @(posedge clk);
                        #1;
                        sme_valid = 1'b0;
                        @(negedge clk);
                        break;
                    end
                    @(negedge clk);
                end
                check("wait_ready_low", bad, 0);
                check("wait_exit_busy", {31'b0, busy}, 0);
                check("wait_exit_ready", {31'b0, in_ready}, 1);
            end
        end else begin
            repeat (3) @(negedge clk);
            check("idle_busy", {31'b0, busy}, 0);
            check("idle_ready", {31'b0, in_ready}, 1);
        end
        check("flag_overflow", {31'b0, err_overflow}, {31'b0, t.e_ovf});
        check("flag_nostr", {31'b0, err_nostr}, {31'b0, t.e_nostr});
        check("flag_timeout", {31'b0, err_timeout}, {31'b0, t.e_to});
    endtask

    initial begin
        sb_t e;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        sme_valid = 1'b0;

        //          rst str  n   ch0    sme exp ovf nostr to
        vecs[0]  = '{1, 1,  3, 8'h41,  0,  3, 0, 0, 0};  // "ABC"
        vecs[1]  = '{0, 0,  2, 8'h42,  6,  2, 0, 0, 0};  // "BC", 5 quiet cycles then result
        vecs[2]  = '{0, 1, 40, 8'h20,  0, 32, 1, 0, 0};  // string truncated to 32
        vecs[3]  = '{0, 0, 10, 8'h30,  1,  8, 1, 0, 0};  // pattern truncated to 8
        vecs[4]  = '{0, 1,  5, 8'h61,  0,  5, 1, 0, 0};  // new string replaces old
        vecs[5]  = '{0, 0,  8, 8'h61, 64,  8, 1, 0, 0};  // result on last timer cycle
        vecs[6]  = '{0, 0,  1, 8'h63,  0,  1, 1, 0, 1};  // no result: timeout
        vecs[7]  = '{1, 0,  1, 8'h58,  0,  0, 0, 1, 0};  // pattern before any string
        vecs[8]  = '{1, 1,  0, 8'h00,  0,  0, 0, 0, 0};  // SOH LF
        vecs[9]  = '{0, 0,  0, 8'h00,  0,  0, 0, 0, 0};  // LF alone
        vecs[10] = '{0, 1, 32, 8'h41,  0, 32, 0, 0, 0};  // exactly STR_MAX
        vecs[11] = '{0, 1, 33, 8'h21,  0, 32, 1, 0, 0};  // STR_MAX + 1

        for (int v = 0; v < NV; v++) run_vec(vecs[v]);

        // Reset on the second cycle of a 5-character string burst.
        do_reset();
        e.is_pat = 1'b0;
        e.ch = 8'h50; sb.push_back(e);
        e.ch = 8'h51; sb.push_back(e);
        send_byte(SOH);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + 8'(i)));
        send_byte(LF);
        @(negedge clk);
        @(negedge clk);
        check("mid_first_active", {31'b0, isstring}, 1);
        @(negedge clk);
        check("mid_second_active", {31'b0, isstring}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_isstring", {31'b0, isstring}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_byte(8'h5A);
        send_byte(LF);
        repeat (3) @(negedge clk);
        check("mid_nostr", {31'b0, err_nostr}, 1);
        check("mid_nostr_idle", {31'b0, busy}, 0);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
